// File: rtl/can_rx_destuff_ctrl.sv
`default_nettype none
// ============================================================================
// Module : can_rx_destuff_ctrl
// Brief  : CAN receive bit sequencer - field tracking, destuffing, stuff/form checks.
// Rev    : 1.0
// ============================================================================
module can_rx_destuff_ctrl (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Sample,
  input  logic       i_Rx_Bit,
  output logic       o_Bit_Valid,
  output logic       o_Bit_Data,
  output logic [6:0] o_Bit_Index,
  output logic [2:0] o_Field,
  output logic       o_In_Stuff,
  output logic       o_Stuff_Removed,
  output logic       o_Stuff_Error,
  output logic       o_Form_Error,
  output logic       o_Frame_Done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DLC   = 3'd2,
    S_DATA  = 3'd3,
    S_CRC   = 3'd4,
    S_TAIL  = 3'd5,
    S_ERROR = 3'd6,
    S_INTEG = 3'd7
  } field_e;

  localparam logic [5:0] C_RTR_BASE      = 6'd11;
  localparam logic [5:0] C_IDE_POS       = 6'd12;
  localparam logic [5:0] C_HDR_BASE_LAST = 6'd13;
  localparam logic [5:0] C_RTR_EXT       = 6'd31;
  localparam logic [5:0] C_HDR_EXT_LAST  = 6'd33;
  localparam logic [5:0] C_DLC_LAST      = 6'd3;
  localparam logic [5:0] C_CRC_LAST      = 6'd14;
  localparam logic [5:0] C_ACK_SLOT      = 6'd1;
  localparam logic [5:0] C_TAIL_LAST     = 6'd9;
  localparam logic [5:0] C_INTEG_LAST    = 6'd10;
  localparam logic [2:0] C_RUN_MAX       = 3'd5;

  field_e     field_q, field_d;
  logic [5:0] cnt_q, cnt_d;
  logic [6:0] data_cnt_q, data_cnt_d;
  logic [2:0] run_q, run_d;
  logic       last_q, last_d;
  logic       rtr_q, rtr_d;
  logic       ide_q, ide_d;
  logic [2:0] dlc_q, dlc_d;
  logic       pend_q, pend_d;
  logic       in_stuff_q, in_stuff_d;
  logic       valid_q, valid_d;
  logic       bit_data_q, bit_data_d;
  logic [6:0] idx_q, idx_d;
  logic       removed_q, removed_d;
  logic       stuff_err_q, stuff_err_d;
  logic       form_err_q, form_err_d;
  logic       done_q, done_d;

  logic       w_emit;
  logic       w_sof;
  logic [2:0] w_run_inc;
  logic [3:0] w_dlc;
  logic [6:0] w_data_bits;

  assign w_run_inc   = (i_Rx_Bit == last_q) ? (run_q + 3'd1) : 3'd1;
  assign w_dlc       = {dlc_q, i_Rx_Bit};
  // DLC values 9..15 still mean eight bytes; remote frames carry no data.
  assign w_data_bits = rtr_q ? 7'd0 : (w_dlc[3] ? 7'd64 : {1'b0, w_dlc[2:0], 3'b000});

  always_comb begin
    field_d     = field_q;
    cnt_d       = cnt_q;
    data_cnt_d  = data_cnt_q;
    run_d       = run_q;
    last_d      = last_q;
    rtr_d       = rtr_q;
    ide_d       = ide_q;
    dlc_d       = dlc_q;
    pend_d      = pend_q;
    in_stuff_d  = in_stuff_q;
    bit_data_d  = bit_data_q;
    idx_d       = idx_q;
    valid_d     = 1'b0;
    removed_d   = 1'b0;
    stuff_err_d = 1'b0;
    form_err_d  = 1'b0;
    done_d      = 1'b0;
    w_emit      = 1'b0;
    w_sof       = 1'b0;

    if (i_Sample) begin
      case (field_q)
        S_INTEG: begin
          if (!i_Rx_Bit) begin
            cnt_d = 6'd0;
          end else if (cnt_q == C_INTEG_LAST) begin
            cnt_d   = 6'd0;
            field_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end

        S_IDLE: begin
          if (!i_Rx_Bit) begin
            w_emit     = 1'b1;
            w_sof      = 1'b1;
            run_d      = 3'd1;
            last_d     = 1'b0;
            cnt_d      = 6'd0;
            rtr_d      = 1'b0;
            ide_d      = 1'b0;
            pend_d     = 1'b0;
            in_stuff_d = 1'b1;
            field_d    = S_HDR;
          end
        end

        S_ERROR: begin
          cnt_d   = {5'd0, i_Rx_Bit};
          field_d = S_INTEG;
        end

        S_TAIL: begin
          if ((cnt_q != C_ACK_SLOT) && !i_Rx_Bit) begin
            form_err_d = 1'b1;
            field_d    = S_ERROR;
          end else begin
            w_emit = 1'b1;
            if (cnt_q == C_TAIL_LAST) begin
              done_d  = 1'b1;
              cnt_d   = 6'd0;
              field_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end

        default: begin
          if (run_q == C_RUN_MAX) begin
            if (i_Rx_Bit != last_q) begin
              removed_d = 1'b1;
              run_d     = 3'd1;
              last_d    = i_Rx_Bit;
              // Stuff bit trailing the CRC closes the stuffed region.
              if (pend_q) begin
                pend_d     = 1'b0;
                in_stuff_d = 1'b0;
                cnt_d      = 6'd0;
                field_d    = S_TAIL;
              end
            end else begin
              stuff_err_d = 1'b1;
              in_stuff_d  = 1'b0;
              pend_d      = 1'b0;
              field_d     = S_ERROR;
            end
          end else begin
            run_d  = w_run_inc;
            last_d = i_Rx_Bit;
            w_emit = 1'b1;
            case (field_q)
              S_HDR: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == C_RTR_BASE) rtr_d = i_Rx_Bit;
                if (cnt_q == C_IDE_POS)  ide_d = i_Rx_Bit;
                if (ide_q && (cnt_q == C_RTR_EXT)) rtr_d = i_Rx_Bit;
                if ((!ide_q && (cnt_q == C_HDR_BASE_LAST)) || (cnt_q == C_HDR_EXT_LAST)) begin
                  cnt_d   = 6'd0;
                  field_d = S_DLC;
                end
              end
              S_DLC: begin
                dlc_d = w_dlc[2:0];
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == C_DLC_LAST) begin
                  cnt_d      = 6'd0;
                  data_cnt_d = w_data_bits;
                  field_d    = (w_data_bits == 7'd0) ? S_CRC : S_DATA;
                end
              end
              S_DATA: begin
                data_cnt_d = data_cnt_q - 7'd1;
                if (data_cnt_q == 7'd1) begin
                  cnt_d   = 6'd0;
                  field_d = S_CRC;
                end
              end
              default: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == C_CRC_LAST) begin
                  cnt_d = 6'd0;
                  if (w_run_inc == C_RUN_MAX) begin
                    pend_d = 1'b1;
                  end else begin
                    in_stuff_d = 1'b0;
                    field_d    = S_TAIL;
                  end
                end
              end
            endcase
          end
        end
      endcase

      if (w_emit) begin
        valid_d    = 1'b1;
        bit_data_d = i_Rx_Bit;
        idx_d      = w_sof ? 7'd0 : (idx_q + 7'd1);
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      field_q     <= S_INTEG;
      cnt_q       <= 6'd0;
      data_cnt_q  <= 7'd0;
      run_q       <= 3'd0;
      last_q      <= 1'b0;
      rtr_q       <= 1'b0;
      ide_q       <= 1'b0;
      dlc_q       <= 3'd0;
      pend_q      <= 1'b0;
      in_stuff_q  <= 1'b0;
      valid_q     <= 1'b0;
      bit_data_q  <= 1'b0;
      idx_q       <= 7'd0;
      removed_q   <= 1'b0;
      stuff_err_q <= 1'b0;
      form_err_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      field_q     <= field_d;
      cnt_q       <= cnt_d;
      data_cnt_q  <= data_cnt_d;
      run_q       <= run_d;
      last_q      <= last_d;
      rtr_q       <= rtr_d;
      ide_q       <= ide_d;
      dlc_q       <= dlc_d;
      pend_q      <= pend_d;
      in_stuff_q  <= in_stuff_d;
      valid_q     <= valid_d;
      bit_data_q  <= bit_data_d;
      idx_q       <= idx_d;
      removed_q   <= removed_d;
      stuff_err_q <= stuff_err_d;
      form_err_q  <= form_err_d;
      done_q      <= done_d;
    end
  end

  assign o_Bit_Valid     = valid_q;
  assign o_Bit_Data      = bit_data_q;
  assign o_Bit_Index     = idx_q;
  assign o_Field         = field_q;
  assign o_In_Stuff      = in_stuff_q;
  assign o_Stuff_Removed = removed_q;
  assign o_Stuff_Error   = stuff_err_q;
  assign o_Form_Error    = form_err_q;
  assign o_Frame_Done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_can_rx_destuff_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_can_rx_destuff_ctrl
// Brief  : Randomized frame-level bench for can_rx_destuff_ctrl with a reference model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_can_rx_destuff_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       smp;
  logic       rxb;
  logic       o_valid;
  logic       o_data;
  logic [6:0] o_idx;
  logic [2:0] o_fld;
  logic       o_ins;
  logic       o_rem;
  logic       o_se;
  logic       o_fe;
  logic       o_dn;

  always #5 clk = ~clk;

  can_rx_destuff_ctrl u_dut (
    .i_Clock         (clk),
    .i_Reset         (rst),
    .i_Sample        (smp),
    .i_Rx_Bit        (rxb),
    .o_Bit_Valid     (o_valid),
    .o_Bit_Data      (o_data),
    .o_Bit_Index     (o_idx),
    .o_Field         (o_fld),
    .o_In_Stuff      (o_ins),
    .o_Stuff_Removed (o_rem),
    .o_Stuff_Error   (o_se),
    .o_Form_Error    (o_fe),
    .o_Frame_Done    (o_dn)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_idx    = 0;
  bit m_data   = 1'b0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One sampled bit, optionally preceded by idle (non-sample) cycles.
  task automatic step(input bit b, input bit ev, input bit erem, input bit ese, input bit efe,
                      input bit edn, input int efld, input bit eins, input string tag);
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      smp = 1'b0;
      @(posedge clk);
      #1;
      check({tag, ".gap_pulses"}, int'({o_valid, o_rem, o_se, o_fe, o_dn}), 0);
    end
    @(negedge clk);
    smp = 1'b1;
    rxb = b;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, int'(o_valid), int'(ev));
    check({tag, ".removed"}, int'(o_rem), int'(erem));
    check({tag, ".stuff_err"}, int'(o_se), int'(ese));
    check({tag, ".form_err"}, int'(o_fe), int'(efe));
    check({tag, ".done"}, int'(o_dn), int'(edn));
    check({tag, ".field"}, int'(o_fld), efld);
    check({tag, ".in_stuff"}, int'(o_ins), int'(eins));
    check({tag, ".index"}, int'(o_idx), m_idx);
    check({tag, ".data"}, int'(o_data), int'(m_data));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    smp = 1'b1;
    rxb = 1'b0;
    @(posedge clk);
    #1;
    m_idx  = 0;
    m_data = 1'b0;
    check("rst.field", int'(o_fld), 7);
    check("rst.index", int'(o_idx), 0);
    check("rst.outs", int'({o_valid, o_data, o_ins, o_rem, o_se, o_fe, o_dn}), 0);
    @(negedge clk);
    rst = 1'b0;
    smp = 1'b0;
  endtask

  // Integration: count of consecutive recessive bits, 11 reaches IDLE.
  task automatic integ_bit(input bit b, inout int cnt);
    cnt = b ? cnt + 1 : 0;
    step(b, 0, 0, 0, 0, 0, (cnt >= 11) ? 0 : 7, 0, "integ");
  endtask

  task automatic recover();
    int cnt;
    bit b;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      b = 1'($urandom_range(0, 1));
      integ_bit(b, cnt);
    end
    while (cnt < 11) integ_bit(1'b1, cnt);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  // err_mode: 0 none, 1 flip a stuff bit (err_sel picks which), 2 zero a required tail bit.
  task automatic run_frame(input string tag, input bit ide, input bit [10:0] id, input bit [17:0] idb,
                           input bit rtr, input bit [3:0] dlc, input bit [14:0] crc,
                           input int err_mode, input int err_sel, input int abort_at,
                           output bit errored);
    bit lg[$];
    bit raw[$];
    bit isst[$];
    int hdr_len, n, crc_end, run, nst, err_j, p, fe_pos, efld, c, t2;
    bit last, ein, ev, er, b;
    errored = 1'b0;

    lg.push_back(1'b0);
    for (int i = 10; i >= 0; i--) lg.push_back(id[i]);
    if (!ide) begin
      lg.push_back(rtr);
      lg.push_back(1'b0);
      lg.push_back(1'($urandom_range(0, 1)));
    end else begin
      lg.push_back(1'b1);
      lg.push_back(1'b1);
      for (int i = 17; i >= 0; i--) lg.push_back(idb[i]);
      lg.push_back(rtr);
      lg.push_back(1'($urandom_range(0, 1)));
      lg.push_back(1'($urandom_range(0, 1)));
    end
    hdr_len = ide ? 34 : 14;
    for (int i = 3; i >= 0; i--) lg.push_back(dlc[i]);
    n = rtr ? 0 : 8 * ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < n; i++) lg.push_back(1'($urandom_range(0, 1)));
    for (int i = 14; i >= 0; i--) lg.push_back(crc[i]);
    crc_end = lg.size() - 1;

    // Standard bit stuffing: complement inserted after every five equal bits.
    run  = 0;
    last = 1'b0;
    foreach (lg[k]) begin
      raw.push_back(lg[k]);
      isst.push_back(1'b0);
      if (k == 0 || lg[k] != last) run = 1;
      else run++;
      last = lg[k];
      if (run == 5) begin
        raw.push_back(!last);
        isst.push_back(1'b1);
        last = !last;
        run  = 1;
      end
    end

    err_j = -1;
    nst   = 0;
    foreach (isst[k]) if (isst[k]) nst++;
    if (err_mode == 1 && nst > 0) begin
      c = err_sel % nst;
      foreach (isst[k]) begin
        if (isst[k]) begin
          if (c == 0 && err_j < 0) err_j = k;
          c--;
        end
      end
    end
    fe_pos = -1;
    if (err_mode == 2) begin
      t2     = err_sel % 9;
      fe_pos = (t2 == 0) ? 0 : t2 + 1;
    end

    p = 0;
    for (int j = 0; j < raw.size(); j++) begin
      if (j == abort_at) return;
      if (isst[j]) begin
        if (j == err_j) begin
          step(!raw[j], 0, 0, 1, 0, 0, 6, 0, {tag, ".stuff_error"});
          errored = 1'b1;
          return;
        end
        ev = 1'b0;
        er = 1'b1;
      end else begin
        m_idx  = p;
        m_data = raw[j];
        p++;
        ev = 1'b1;
        er = 1'b0;
      end
      if (p <= crc_end) begin
        efld = (p <= hdr_len) ? 1 : (p <= hdr_len + 4) ? 2 : (p <= hdr_len + 4 + n) ? 3 : 4;
        ein  = 1'b1;
      end else if (j + 1 < raw.size() && isst[j + 1]) begin
        efld = 4;
        ein  = 1'b1;
      end else begin
        efld = 5;
        ein  = 1'b0;
      end
      step(raw[j], ev, er, 0, 0, 0, efld, ein, tag);
    end

    for (int t = 0; t < 10; t++) begin
      if (t == fe_pos) begin
        step(1'b0, 0, 0, 0, 1, 0, 6, 0, {tag, ".form_error"});
        errored = 1'b1;
        return;
      end
      b      = (t == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      m_idx  = crc_end + 1 + t;
      m_data = b;
      step(b, 1, 0, 0, 0, (t == 9), (t == 9) ? 0 : 5, 0, {tag, ".tail"});
    end
  endtask

  initial begin
    int  cnt;
    bit  er;
    bit  ide;
    bit  rtr;
    int  mode;
    rst = 1'b0;
    smp = 1'b0;
    rxb = 1'b1;

    do_reset();
    cnt = 0;
    for (int i = 0; i < 10; i++) integ_bit(1'b1, cnt);
    integ_bit(1'b0, cnt);
    for (int i = 0; i < 11; i++) integ_bit(1'b1, cnt);

    run_frame("base_id0", 1'b0, 11'd0, 18'd0, 1'b0, 4'd0, 15'd0, 0, 0, -1, er);
    send_idle(2);
    run_frame("stuff_err", 1'b0, 11'd0, 18'd0, 1'b0, 4'd0, 15'd0, 1, 0, -1, er);
    recover();
    run_frame("dlc15", 1'b0, 11'($urandom), 18'd0, 1'b0, 4'd15, 15'($urandom), 0, 0, -1, er);
    send_idle(1);
    run_frame("rtr_dlc8", 1'b0, 11'($urandom), 18'd0, 1'b1, 4'd8, 15'($urandom), 0, 0, -1, er);
    run_frame("crc_stuff", 1'b0, 11'($urandom), 18'd0, 1'b0, 4'd1, 15'b101010101011111, 0, 0, -1, er);
    run_frame("ext_ackdel", 1'b1, 11'($urandom), 18'($urandom), 1'b0, 4'd8, 15'($urandom), 2, 1, -1, er);
    recover();
    run_frame("ext_ok", 1'b1, 11'($urandom), 18'($urandom), 1'b0, 4'd8, 15'($urandom), 0, 0, -1, er);
    check("ext_ok.final_index", int'(o_idx), 127);

    run_frame("abort", 1'b1, 11'($urandom), 18'($urandom), 1'b0, 4'd3, 15'($urandom), 0, 0, 20, er);
    do_reset();
    recover();

    for (int f = 0; f < 40; f++) begin
      ide  = 1'($urandom_range(0, 1));
      rtr  = ($urandom_range(0, 3) == 0);
      mode = $urandom_range(0, 3);
      if (mode == 3) mode = 0;
      run_frame("rand", ide, 11'($urandom), 18'($urandom), rtr, 4'($urandom), 15'($urandom),
                mode, $urandom_range(0, 40), -1, er);
      if (er) recover();
      else send_idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
